// File: rtl/debug_loader.sv
// UART-driven program loader and run/step/dump controller; all outputs registered, TX waits on tx_busy.
// DEBUG_LOADER_TIMEOUT_EN adds an idle-byte abort (NAK) while a load is in progress.
module debug_loader #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              cpu_enable,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              halt_in
);

`ifdef DEBUG_LOADER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [3:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, RUN, STEP, DUMP, TX} state_t;
  typedef enum logic [1:0] {TX_WAIT, TX_PULSE, TX_SKIP} tx_phase_t;

  state_t            state;
  tx_phase_t         tx_phase;
  logic [31:0]       cycle_count;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       data_sr;
  logic [47:0]       tx_sr;
  logic [2:0]        tx_left;
  logic [31:0]       idle_count;
  logic              in_load;
  logic              timeout;

  assign in_load = (state == CNT_HI) || (state == CNT_LO) || (state == DATA);
  assign timeout = TIMEOUT_EN && in_load && (idle_count == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset || !in_load || rx_valid) begin
      idle_count <= '0;
    end else if (TIMEOUT_EN) begin
      idle_count <= idle_count + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tx_phase    <= TX_WAIT;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_reset   <= 1'b0;
      cpu_enable  <= 1'b0;
      cycle_count <= '0;
      word_count  <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      data_sr     <= '0;
      tx_sr       <= '0;
      tx_left     <= '0;
    end else begin
      tx_start <= 1'b0;
      imem_we  <= 1'b0;
      if (cpu_enable) cycle_count <= cycle_count + 32'd1;

      if (timeout) begin
        state     <= TX;
        tx_phase  <= TX_WAIT;
        tx_sr     <= {NAK, 40'd0};
        tx_left   <= 3'd1;
        cpu_reset <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              case (rx_data)
                CMD_LOAD: begin
                  state     <= CNT_HI;
                  cpu_reset <= 1'b1;
                end
                CMD_RUN: begin
                  state      <= RUN;
                  cpu_enable <= 1'b1;
                end
                CMD_STEP: begin
                  state      <= STEP;
                  cpu_enable <= 1'b1;
                end
                CMD_DUMP: state <= DUMP;
                default: begin
                  state    <= TX;
                  tx_phase <= TX_WAIT;
                  tx_sr    <= {NAK, 40'd0};
                  tx_left  <= 3'd1;
                end
              endcase
            end
          end
          CNT_HI: begin
            if (rx_valid) begin
              word_count[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
              state                  <= CNT_LO;
            end
          end
          CNT_LO: begin
            if (rx_valid) begin
              if ({word_count[ADDR_W-1:8], rx_data} == '0) begin
                state       <= TX;
                tx_phase    <= TX_WAIT;
                tx_sr       <= {ACK, 40'd0};
                tx_left     <= 3'd1;
                cpu_reset   <= 1'b0;
                cycle_count <= '0;
              end else begin
                word_count[7:0] <= rx_data;
                word_idx        <= '0;
                byte_idx        <= '0;
                state           <= DATA;
              end
            end
          end
          DATA: begin
            if (rx_valid) begin
              // big-endian: first byte ends up in bits 31:24
              data_sr  <= {data_sr[15:0], rx_data};
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx;
                imem_wdata <= {data_sr, rx_data};
                state      <= WRITE;
              end
            end
          end
          WRITE: begin
            word_idx <= word_idx + ADDR_W'(1);
            if (word_idx + ADDR_W'(1) == word_count) begin
              state       <= TX;
              tx_phase    <= TX_WAIT;
              tx_sr       <= {ACK, 40'd0};
              tx_left     <= 3'd1;
              cpu_reset   <= 1'b0;
              cycle_count <= '0;
            end else begin
              state <= DATA;
            end
          end
          RUN: begin
            if (halt_in || (rx_valid && rx_data == CMD_PAUSE)) begin
              cpu_enable <= 1'b0;
              state      <= DUMP;
            end
          end
          STEP: begin
            cpu_enable <= 1'b0;
            state      <= DUMP;
          end
          DUMP: begin
            tx_sr    <= {16'(pc_in), cycle_count};
            tx_left  <= 3'd6;
            tx_phase <= TX_WAIT;
            state    <= TX;
          end
          TX: begin
            // pulse, one skip cycle so the UART can raise busy, then wait again
            case (tx_phase)
              TX_WAIT: begin
                if (!tx_busy) begin
                  tx_data  <= tx_sr[47:40];
                  tx_start <= 1'b1;
                  tx_sr    <= {tx_sr[39:0], 8'd0};
                  tx_left  <= tx_left - 3'd1;
                  tx_phase <= TX_PULSE;
                end
              end
              TX_PULSE: tx_phase <= TX_SKIP;
              TX_SKIP: begin
                tx_phase <= TX_WAIT;
                if (tx_left == 3'd0) state <= IDLE;
              end
              default: tx_phase <= TX_WAIT;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
